dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 4, meaning the maximum number of consecutive DMA grants while cpu_req is pending (legal range 1-15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have CPU (MEM stage) ports: cpu_req in 1; cpu_we in 1; cpu_size in 2 (00 byte, 01 half, 10 word, 11 illegal); cpu_addr in 32; cpu_wdata in 32; cpu_rdata out 32; cpu_ready out 1 (low = stall the pipeline); cpu_err out 1.
REQ-005 The block SHALL have DMA ports: dma_req in 1; dma_we in 1; dma_size in 2; dma_addr in 32; dma_wdata in 32; dma_last in 1 (final beat of burst); dma_gnt out 1; dma_rdata out 32; dma_rvalid out 1; dma_err out 1.
REQ-006 The block SHALL have data-memory ports: mem_addr out 32; mem_write_data out 32; mem_read_en out 1; mem_write_byte_en out 1; mem_write_half_en out 1; mem_write_word_en out 1; mem_read_data in 32 (combinational read, synchronous write).

Function
REQ-007 State: FSM {IDLE, DMA_BURST}; burst_cnt 4 bits; registered dma_rdata and dma_rvalid.
REQ-008 Owner per cycle: if state=DMA_BURST, dma_req=1 and burst_cnt<MAX_BURST -> DMA; else cpu_req=1 -> CPU; else dma_req=1 -> DMA; else none.
REQ-009 Exactly one requester SHALL access memory per cycle; the owner's addr/wdata drive mem_addr/mem_write_data (CPU fields when no owner).
REQ-010 Alignment: access is legal iff size=00, or size=01 and addr[0]=0, or size=10 and addr[1:0]=00; size=11 is illegal.
REQ-011 Write enables: for a legal owner write, exactly one of byte/half/word enables SHALL be 1 per size; illegal or read accesses SHALL assert none.
REQ-012 mem_read_en SHALL be 1 iff owner exists, owner we=0 and the access is legal.
REQ-013 cpu_ready = !cpu_req or CPU is owner (combinational); cpu_rdata = mem_read_data in the owner cycle, 0 otherwise.
REQ-014 cpu_err SHALL equal 1 in the CPU-owner cycle of an illegal access; the access SHALL still complete (cpu_ready=1).
REQ-015 dma_gnt SHALL be 1 exactly in DMA-owner cycles; dma_err SHALL be 1 in a DMA-owner cycle with an illegal access.
REQ-016 DMA read: one cycle after a granted legal DMA read, dma_rvalid=1 and dma_rdata=mem_read_data captured at grant; otherwise dma_rvalid=0 and dma_rdata holds its value.
REQ-017 Transitions: IDLE->DMA_BURST on a DMA grant with dma_last=0 (burst_cnt<=1); in DMA_BURST each DMA grant increments burst_cnt (saturating at 15).
REQ-018 DMA_BURST->IDLE (burst_cnt<=0) when: granted beat has dma_last=1; or dma_req=0; or burst_cnt>=MAX_BURST and cpu_req=1 (CPU then owns that cycle).
REQ-019 If burst_cnt>=MAX_BURST and cpu_req=0, DMA SHALL continue being granted and the state SHALL remain DMA_BURST.
REQ-020 Burst limit SHALL bound CPU stall to MAX_BURST consecutive cycles once a burst has started.
REQ-021 Simultaneous cpu_req and dma_req in IDLE: CPU wins; DMA waits with dma_gnt=0.
REQ-022 dma_last with a single-beat grant from IDLE SHALL leave the state in IDLE.

Reset
REQ-023 While rst=1: state<=IDLE, burst_cnt<=0, dma_rvalid<=0, dma_rdata<=0.
REQ-024 While rst=1 combinational outputs SHALL be forced inactive: all write enables 0, mem_read_en 0, dma_gnt 0, cpu_ready 0, cpu_err 0, dma_err 0, cpu_rdata 0.
REQ-025 Reset asserted mid-burst SHALL abort the burst; first cycle after reset follows IDLE priority.

Verification
REQ-026 CPU write size=10 addr 0x10 data 0xDEADBEEF, no DMA -> mem_write_word_en=1, cpu_ready=1, cpu_err=0; later CPU read 0x10 -> cpu_rdata=0xDEADBEEF same cycle.
REQ-027 CPU half write addr 0x13 -> cpu_err=1, no write enable, cpu_ready=1; DMA word read addr 0x02 -> dma_err=1, dma_rvalid=0 next cycle.
REQ-028 cpu_req and dma_req both rise in IDLE -> CPU granted cycle 0, dma_gnt=1 cycle 1 after cpu_req drops.
REQ-029 MAX_BURST=4, DMA 8-beat read burst, cpu_req rises after beat 1 -> dma_gnt 4 cycles, cpu_ready low 3 cycles, CPU owns cycle 5, DMA resumes cycle 6; each beat gives dma_rvalid=1 next cycle with correct data.
REQ-030 DMA burst with cpu_req=0 throughout, 6 beats, dma_last on beat 6 -> 6 contiguous grants, state IDLE after.
REQ-031 rst=1 during beat 2 of a burst -> dma_gnt=0, no write enables that cycle, dma_rvalid=0 next cycle; after release CPU request wins over pending DMA.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU MEM stage and a DMA master.
// Bounded DMA bursts keep the CPU stall to at most MAX_BURST cycles.
module dmem_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [1:0]  dma_size,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic        dma_last,
  output logic        dma_gnt,
  output logic [31:0] dma_rdata,
  output logic        dma_rvalid,
  output logic        dma_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_read_en,
  output logic        mem_write_byte_en,
  output logic        mem_write_half_en,
  output logic        mem_write_word_en,
  input  logic [31:0] mem_read_data
);

  typedef enum logic {IDLE, DMA_BURST} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  state_t      state, state_nxt;
  logic [3:0]  burst_cnt, burst_cnt_nxt;
  logic        burst_hold;
  logic        cpu_own, dma_own, any_own;
  logic        own_we, own_legal;
  logic [1:0]  own_size;
  logic [31:0] own_addr;

  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] a);
    return (size == 2'b00) ||
           (size == 2'b01 && !a[0]) ||
           (size == 2'b10 && a == 2'b00);
  endfunction

  // An in-progress burst keeps the memory until it reaches its limit.
  always_comb begin
    burst_hold = (state == DMA_BURST) && dma_req && (burst_cnt < MAX_CNT);
    dma_own    = !rst && (burst_hold || (!cpu_req && dma_req));
    cpu_own    = !rst && cpu_req && !burst_hold;
    any_own    = cpu_own || dma_own;
    own_we     = dma_own ? dma_we   : cpu_we;
    own_size   = dma_own ? dma_size : cpu_size;
    own_addr   = dma_own ? dma_addr : cpu_addr;
    own_legal  = is_legal(own_size, own_addr[1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      burst_cnt  <= 4'd0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= 32'd0;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= burst_cnt_nxt;
      dma_rvalid <= dma_own && !dma_we && own_legal;
      if (dma_own && !dma_we && own_legal)
        dma_rdata <= mem_read_data;
    end
  end

  // Any cycle that is not a continuing DMA beat closes the burst.
  always_comb begin
    state_nxt     = IDLE;
    burst_cnt_nxt = 4'd0;
    if (dma_own && !dma_last) begin
      state_nxt = DMA_BURST;
      if (state == IDLE)
        burst_cnt_nxt = 4'd1;
      else if (burst_cnt == 4'hF)
        burst_cnt_nxt = 4'hF;
      else
        burst_cnt_nxt = burst_cnt + 4'd1;
    end
  end

  always_comb begin
    mem_addr          = own_addr;
    mem_write_data    = dma_own ? dma_wdata : cpu_wdata;
    mem_read_en       = any_own && !own_we && own_legal;
    mem_write_byte_en = any_own && own_we && own_legal && (own_size == 2'b00);
    mem_write_half_en = any_own && own_we && own_legal && (own_size == 2'b01);
    mem_write_word_en = any_own && own_we && own_legal && (own_size == 2'b10);
    cpu_ready         = !rst && (!cpu_req || cpu_own);
    cpu_err           = cpu_own && !own_legal;
    cpu_rdata         = cpu_own ? mem_read_data : 32'd0;
    dma_gnt           = dma_own;
    dma_err           = dma_own && !own_legal;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic,
// compared each cycle against a rule-level arbitration and memory model.
module tb_dmem_arbiter;
  localparam int MAX = 4;

  logic        clk, rst;
  logic        cpu_req, cpu_we, cpu_ready, cpu_err;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_last, dma_gnt, dma_rvalid, dma_err;
  logic [1:0]  dma_size;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_read_en, mem_write_byte_en, mem_write_half_en, mem_write_word_en;

  logic [31:0] mem [64];
  assign mem_read_data = mem[mem_addr[7:2]];

  dmem_arbiter #(.MAX_BURST(MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_size(dma_size), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
    .dma_rvalid(dma_rvalid), .dma_err(dma_err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_en(mem_read_en),
    .mem_write_byte_en(mem_write_byte_en), .mem_write_half_en(mem_write_half_en),
    .mem_write_word_en(mem_write_word_en), .mem_read_data(mem_read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_pass = 0, n_total = 0;
  bit          m_burst = 0;
  int          m_beats = 0;
  bit          m_rvalid = 0;
  logic [31:0] m_rdata = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic bit legal(input logic [1:0] sz, input logic [1:0] a);
    return sz == 2'd0 || (sz == 2'd1 && a[0] == 1'b0) || (sz == 2'd2 && a == 2'd0);
  endfunction

  // One clock: check all outputs at the falling edge, then advance model and memory.
  task automatic tick();
    int          own;
    bit          lg, w, wb, wh, ww;
    logic [1:0]  sz;
    logic [31:0] a, wd;
    @(negedge clk);
    if (rst) own = 0;
    else if (m_burst && dma_req && m_beats < MAX) own = 2;
    else if (cpu_req) own = 1;
    else if (dma_req) own = 2;
    else own = 0;
    a  = (own == 2) ? dma_addr  : cpu_addr;
    wd = (own == 2) ? dma_wdata : cpu_wdata;
    sz = (own == 2) ? dma_size  : cpu_size;
    w  = (own == 2) ? dma_we    : cpu_we;
    lg = legal(sz, a[1:0]);
    chk("mem_addr", mem_addr, a);
    chk("mem_wdata", mem_write_data, wd);
    chk("mem_read_en", mem_read_en, 32'(own != 0 && !w && lg));
    chk("we_byte", mem_write_byte_en, 32'(own != 0 && w && lg && sz == 2'd0));
    chk("we_half", mem_write_half_en, 32'(own != 0 && w && lg && sz == 2'd1));
    chk("we_word", mem_write_word_en, 32'(own != 0 && w && lg && sz == 2'd2));
    chk("cpu_ready", cpu_ready, 32'(!rst && (!cpu_req || own == 1)));
    chk("cpu_err", cpu_err, 32'(own == 1 && !lg));
    chk("cpu_rdata", cpu_rdata, (own == 1) ? mem[cpu_addr[7:2]] : 32'd0);
    chk("dma_gnt", dma_gnt, 32'(own == 2));
    chk("dma_err", dma_err, 32'(own == 2 && !lg));
    chk("dma_rvalid", dma_rvalid, 32'(m_rvalid));
    chk("dma_rdata", dma_rdata, m_rdata);
    if (rst) begin
      m_burst = 0; m_beats = 0; m_rvalid = 0; m_rdata = 32'd0;
    end else begin
      m_rvalid = (own == 2) && !w && lg;
      if (m_rvalid) m_rdata = mem[dma_addr[7:2]];
      if (own == 2 && !dma_last) begin
        m_beats = m_burst ? ((m_beats >= 15) ? 15 : m_beats + 1) : 1;
        m_burst = 1;
      end else begin
        m_burst = 0; m_beats = 0;
      end
    end
    wb = mem_write_byte_en; wh = mem_write_half_en; ww = mem_write_word_en;
    a = mem_addr; wd = mem_write_data;
    @(posedge clk);
    if (ww) mem[a[7:2]] = wd;
    else if (wh) mem[a[7:2]][16*int'(a[1]) +: 16] = wd[15:0];
    else if (wb) mem[a[7:2]][8*int'(a[1:0]) +: 8] = wd[7:0];
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_size = 2'd2; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    dma_req = 0; dma_we = 0; dma_size = 2'd2; dma_addr = 32'd0; dma_wdata = 32'd0;
    dma_last = 0;
  endtask

  initial begin
    int          k, g, cyc;
    bit          got, cpu_done;
    logic [5:0]  gnt_v;
    logic [3:0]  rdy_v;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1234_0000 + 32'(i * 32'h0101);
    idle();
    rst = 1;
    @(posedge clk); #1;
    #1;
    chk("rst_ready", cpu_ready, 0);
    chk("rst_gnt", dma_gnt, 0);
    tick();
    rst = 0;

    // CPU word write then read back
    cpu_req = 1; cpu_we = 1; cpu_size = 2'd2; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    #1;
    chk("r26_we_word", mem_write_word_en, 1);
    chk("r26_ready", cpu_ready, 1);
    chk("r26_err", cpu_err, 0);
    tick();
    idle(); tick();
    cpu_req = 1; cpu_we = 0; cpu_size = 2'd2; cpu_addr = 32'h10;
    #1;
    chk("r26_rdata", cpu_rdata, 32'hDEADBEEF);
    tick();

    // Misaligned accesses
    idle(); cpu_req = 1; cpu_we = 1; cpu_size = 2'd1; cpu_addr = 32'h13; cpu_wdata = 32'h5555;
    #1;
    chk("r27_cpu_err", cpu_err, 1);
    chk("r27_no_we", {mem_write_byte_en, mem_write_half_en, mem_write_word_en}, 0);
    chk("r27_ready", cpu_ready, 1);
    tick();
    idle(); dma_req = 1; dma_size = 2'd2; dma_addr = 32'h02; dma_last = 1;
    #1;
    chk("r27_dma_err", dma_err, 1);
    tick();
    idle();
    #1;
    chk("r27_no_rvalid", dma_rvalid, 0);
    tick();

    // Simultaneous requests in IDLE
    cpu_req = 1; cpu_addr = 32'h20; dma_req = 1; dma_addr = 32'h24; dma_last = 1;
    #1;
    chk("r28_cpu_first", cpu_ready, 1);
    chk("r28_dma_wait", dma_gnt, 0);
    tick();
    cpu_req = 0;
    #1;
    chk("r28_dma_next", dma_gnt, 1);
    tick();
    idle(); tick();

    // 8-beat DMA read burst interrupted by the CPU
    k = 0; cpu_done = 0; gnt_v = '0; rdy_v = '0;
    for (int c = 0; c < 20 && k < 8; c++) begin
      dma_req = 1; dma_we = 0; dma_size = 2'd2; dma_addr = 32'h40 + 32'(4 * k);
      dma_last = (k == 7);
      cpu_req = (c >= 1) && !cpu_done; cpu_we = 0; cpu_addr = 32'h20;
      #1;
      if (c < 6) gnt_v[c] = dma_gnt;
      if (c >= 1 && c <= 4) rdy_v[c-1] = cpu_ready;
      got = dma_gnt;
      if (cpu_req && cpu_ready) cpu_done = 1;
      tick();
      if (got) k++;
    end
    chk("r29_beats", k, 8);
    chk("r29_gnt_pattern", gnt_v, 6'b101111);
    chk("r29_ready_pattern", rdy_v, 4'b1000);
    idle(); tick();

    // 6-beat write burst, no CPU traffic
    k = 0; g = 0; cyc = 0;
    for (int c = 0; c < 12 && k < 6; c++) begin
      cpu_req = 0; dma_req = 1; dma_we = 1; dma_size = 2'd2;
      dma_addr = 32'h80 + 32'(4 * k); dma_wdata = $urandom; dma_last = (k == 5);
      #1;
      got = dma_gnt;
      if (got) g++;
      cyc++;
      tick();
      if (got) k++;
    end
    chk("r30_grants", g, 6);
    chk("r30_contiguous", cyc, 6);
    dma_we = 0; dma_addr = 32'hA0; dma_last = 0;
    tick();
    cpu_req = 1; cpu_addr = 32'h30;
    #1;
    chk("r30_new_burst", dma_gnt, 1);
    tick();
    dma_last = 1; cpu_req = 0;
    tick();
    idle(); tick();

    // Reset mid-burst
    dma_req = 1; dma_addr = 32'h44; dma_last = 0;
    #1;
    chk("r31_beat1", dma_gnt, 1);
    tick();
    dma_addr = 32'h48; rst = 1;
    #1;
    chk("r31_rst_gnt", dma_gnt, 0);
    chk("r31_rst_en", {mem_read_en, mem_write_byte_en, mem_write_half_en, mem_write_word_en}, 0);
    tick();
    rst = 0; cpu_req = 1; cpu_addr = 32'h4C;
    #1;
    chk("r31_rvalid", dma_rvalid, 0);
    chk("r31_cpu_wins", cpu_ready, 1);
    chk("r31_dma_waits", dma_gnt, 0);
    tick();
    idle(); tick();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      rst       = ($urandom_range(0, 59) == 0);
      cpu_req   = ($urandom_range(0, 9) < 4);
      cpu_we    = $urandom_range(0, 1);
      cpu_size  = 2'($urandom_range(0, 3));
      cpu_addr  = {24'd0, 8'($urandom)};
      cpu_wdata = $urandom;
      dma_req   = ($urandom_range(0, 9) < 6);
      dma_we    = $urandom_range(0, 1);
      dma_size  = 2'($urandom_range(0, 3));
      dma_addr  = {24'd0, 8'($urandom)};
      dma_wdata = $urandom;
      dma_last  = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
